// File: rtl/byte_packer_if.sv
// Byte-in / word-out stream bundle for byte_packer.
// The slave modport is the packer's view; master is the environment around it.
interface byte_packer_if #(
  parameter int NUM_BYTES = 4
);
  logic                   i_valid_i;
  logic [7:0]             i_data_i;
  logic                   i_last_i;
  logic                   i_ready_o;
  logic                   e_ready_i;
  logic                   e_valid_o;
  logic [8*NUM_BYTES-1:0] e_data_o;
  logic [NUM_BYTES-1:0]   e_keep_o;
  logic                   e_last_o;

  modport slave (
    input  i_valid_i, i_data_i, i_last_i, e_ready_i,
    output i_ready_o, e_valid_o, e_data_o, e_keep_o, e_last_o
  );

  modport master (
    output i_valid_i, i_data_i, i_last_i, e_ready_i,
    input  i_ready_o, e_valid_o, e_data_o, e_keep_o, e_last_o
  );
endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian NUM_BYTES-wide words with keep/last,
// flushing a partial word early when the input marks the last byte of a packet.
module byte_packer #(
  parameter int NUM_BYTES = 4
) (
  input logic          clk,
  input logic          reset_n,
  byte_packer_if.slave bus
);
  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST_POS = CW'(NUM_BYTES - 1);

  logic [NUM_BYTES-2:0][7:0] acc_data;
  logic [CW-1:0]             acc_cnt;

  logic                      out_valid_q;
  logic [NUM_BYTES-1:0][7:0] out_data_q;
  logic [NUM_BYTES-1:0]      out_keep_q;
  logic                      out_last_q;

  logic                      in_ready;
  logic                      accept;
  logic                      complete;
  logic [NUM_BYTES-1:0][7:0] word_d;
  logic [NUM_BYTES-1:0]      keep_d;

  // A stalled word blocks intake; a draining word lets the next byte in.
  assign in_ready = ~out_valid_q | bus.e_ready_i;
  assign accept   = bus.i_valid_i & in_ready;
  assign complete = accept & ((acc_cnt == LAST_POS) | bus.i_last_i);

  // Stale accumulator bytes at or above acc_cnt are masked to zero here.
  always_comb begin
    word_d = '0;
    keep_d = '0;
    for (int k = 0; k < NUM_BYTES - 1; k++) begin
      if (CW'(k) < acc_cnt) word_d[k] = acc_data[k];
    end
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (CW'(k) == acc_cnt) word_d[k] = bus.i_data_i;
      keep_d[k] = (CW'(k) <= acc_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt  <= '0;
      acc_data <= '0;
    end else if (accept) begin
      if (complete) begin
        acc_cnt <= '0;
      end else begin
        acc_cnt <= acc_cnt + 1'b1;
        for (int k = 0; k < NUM_BYTES - 1; k++) begin
          if (CW'(k) == acc_cnt) acc_data[k] <= bus.i_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word_d;
      out_keep_q  <= keep_d;
      out_last_q  <= bus.i_last_i;
    end else if (bus.e_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.i_ready_o = in_ready;
  assign bus.e_valid_o = out_valid_q;
  assign bus.e_data_o  = out_data_q;
  assign bus.e_keep_o  = out_keep_q;
  assign bus.e_last_o  = out_last_q;
endmodule

// File: tb/tb_byte_packer.sv
// Directed plus randomized bench for byte_packer against a queue-based packet model.
module tb_byte_packer;
  localparam int N  = 4;
  localparam int WW = 8 * N;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  byte_packer_if #(.NUM_BYTES(N)) bif ();

  byte_packer #(.NUM_BYTES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference: bytes collect in a queue; a word forms when it reaches N or a last byte arrives.
  logic [7:0]    cur[$];
  bit            m_valid = 0;
  logic [WW-1:0] m_data  = '0;
  logic [N-1:0]  m_keep  = '0;
  bit            m_last  = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur.delete();
      m_valid = 0;
      m_data  = '0;
      m_keep  = '0;
      m_last  = 0;
    end else begin
      bit rdy;
      rdy = !m_valid || bif.e_ready_i;
      if (m_valid && bif.e_ready_i) m_valid = 0;
      if (bif.i_valid_i && rdy) begin
        cur.push_back(bif.i_data_i);
        if (cur.size() == N || bif.i_last_i) begin
          m_data = '0;
          foreach (cur[k]) m_data = m_data | (WW'(cur[k]) << (8 * k));
          m_keep  = N'((1 << cur.size()) - 1);
          m_last  = bif.i_last_i;
          m_valid = 1;
          cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bif.i_ready_o !== (!m_valid || bif.e_ready_i)) begin
      errors++;
      $display("FAIL cmp_ready t=%0t: got %b expected %b", $time, bif.i_ready_o, (!m_valid || bif.e_ready_i));
    end
    checks++;
    if (bif.e_valid_o !== m_valid) begin
      errors++;
      $display("FAIL cmp_valid t=%0t: got %b expected %b", $time, bif.e_valid_o, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (bif.e_data_o !== m_data || bif.e_keep_o !== m_keep || bif.e_last_o !== m_last) begin
        errors++;
        $display("FAIL cmp_word t=%0t: got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                 $time, bif.e_data_o, bif.e_keep_o, bif.e_last_o, m_data, m_keep, m_last);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit r);
    bif.i_valid_i = v;
    bif.i_data_i  = d;
    bif.i_last_i  = l;
    bif.e_ready_i = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.i_valid_i = 0;
    bif.i_data_i  = '0;
    bif.i_last_i  = 0;
    bif.e_ready_i = 1;
    #1;
    chk("rst_ready_during", 64'(bif.i_ready_o), 64'h1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    chk("rst_valid", 64'(bif.e_valid_o), 64'h0);
    chk("rst_data", 64'(bif.e_data_o), 64'h0);
    chk("rst_keep", 64'(bif.e_keep_o), 64'h0);
    chk("rst_last", 64'(bif.e_last_o), 64'h0);
    chk("rst_ready_after", 64'(bif.i_ready_o), 64'h1);

    // Full word
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    cyc(1, 8'h33, 0, 1);
    chk("t1_pre_valid", 64'(bif.e_valid_o), 64'h0);
    cyc(1, 8'h44, 0, 1);
    chk("t1_valid", 64'(bif.e_valid_o), 64'h1);
    chk("t1_data", 64'(bif.e_data_o), 64'h44332211);
    chk("t1_keep", 64'(bif.e_keep_o), 64'hF);
    chk("t1_last", 64'(bif.e_last_o), 64'h0);

    // Early flush and lone last byte
    cyc(1, 8'hAA, 0, 1);
    cyc(1, 8'hBB, 1, 1);
    chk("t2_data", 64'(bif.e_data_o), 64'h0000BBAA);
    chk("t2_keep", 64'(bif.e_keep_o), 64'h3);
    chk("t2_last", 64'(bif.e_last_o), 64'h1);
    cyc(1, 8'hCC, 1, 1);
    chk("t2_lone_data", 64'(bif.e_data_o), 64'h000000CC);
    chk("t2_lone_keep", 64'(bif.e_keep_o), 64'h1);
    chk("t2_lone_last", 64'(bif.e_last_o), 64'h1);

    // Backpressure
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    cyc(1, 8'h33, 0, 1);
    cyc(1, 8'h44, 0, 1);
    for (int i = 0; i < 5; i++) begin
      bif.i_valid_i = 1;
      bif.i_data_i  = 8'h99;
      bif.i_last_i  = 1;
      bif.e_ready_i = 0;
      #1;
      chk("t3_stall_ready", 64'(bif.i_ready_o), 64'h0);
      @(posedge clk);
      #1;
      chk("t3_stall_valid", 64'(bif.e_valid_o), 64'h1);
      chk("t3_stall_data", 64'(bif.e_data_o), 64'h44332211);
    end
    bif.i_valid_i = 0;
    bif.i_last_i  = 0;
    bif.e_ready_i = 1;
    #1;
    chk("t3_release_ready", 64'(bif.i_ready_o), 64'h1);
    @(posedge clk);
    #1;
    chk("t3_drained", 64'(bif.e_valid_o), 64'h0);

    // Throughput
    for (int i = 1; i <= 8; i++) begin
      bif.i_valid_i = 1;
      bif.i_data_i  = 8'(i);
      bif.i_last_i  = 0;
      bif.e_ready_i = 1;
      #1;
      chk("t4_ready", 64'(bif.i_ready_o), 64'h1);
      @(posedge clk);
      #1;
      if (i == 4) chk("t4_word0", 64'(bif.e_data_o), 64'h04030201);
      if (i == 8) chk("t4_word1", 64'(bif.e_data_o), 64'h08070605);
    end

    // Reset mid-word
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    bif.i_valid_i = 0;
    reset_n = 0;
    #1;
    chk("t5_rst_valid", 64'(bif.e_valid_o), 64'h0);
    chk("t5_rst_ready", 64'(bif.i_ready_o), 64'h1);
    @(posedge clk);
    #1;
    reset_n = 1;
    cyc(1, 8'h55, 0, 1);
    chk("t5_valid_a", 64'(bif.e_valid_o), 64'h0);
    cyc(1, 8'h66, 0, 1);
    cyc(1, 8'h77, 0, 1);
    chk("t5_valid_b", 64'(bif.e_valid_o), 64'h0);
    cyc(1, 8'h88, 0, 1);
    chk("t5_data", 64'(bif.e_data_o), 64'h88776655);
    chk("t5_keep", 64'(bif.e_keep_o), 64'hF);

    // Simultaneous drain and complete
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    cyc(1, 8'h33, 0, 1);
    cyc(1, 8'h44, 0, 1);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("t6_pending", 64'(bif.e_data_o), 64'h44332211);
    cyc(1, 8'hDD, 1, 1);
    chk("t6_valid", 64'(bif.e_valid_o), 64'h1);
    chk("t6_data", 64'(bif.e_data_o), 64'h000000DD);
    chk("t6_keep", 64'(bif.e_keep_o), 64'h1);
    cyc(0, 8'h00, 0, 1);
    chk("t6_drained", 64'(bif.e_valid_o), 64'h0);

    // Randomized traffic; the negedge compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        bif.i_valid_i = 0;
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
      end
      cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 6);
    end

    cyc(0, 8'h00, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
